param_acc_cpu: RTL and testbench
================================

PARAM_ACC_CPU -- requirements
Module: param_acc_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of accumulator, instruction and memory data.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning width of PC and memory address; legal only if DATA_W >= ADDR_W+4.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port mem_req, output, 1, memory access request.
REQ-006 SHALL have port mem_we, output, 1, write qualifier, valid only with mem_req.
REQ-007 SHALL have port mem_addr, output, ADDR_W, access address.
REQ-008 SHALL have port mem_wdata, output, DATA_W, write data, always equal to AC.
REQ-009 SHALL have port mem_rdata, input, DATA_W, read data, sampled only when mem_req and mem_ready are both 1.
REQ-010 SHALL have port mem_ready, input, 1, access completes on any edge where mem_req=1 and mem_ready=1.
REQ-011 SHALL have ports PC (ADDR_W), IR (DATA_W) and AC (DATA_W), all outputs, giving the architectural registers for debug.
REQ-012 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-013 SHALL be a three-state FSM: FETCH, EXECUTE and HALT.
REQ-014 FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ready: IR<=mem_rdata, PC<=PC+1 modulo 2^ADDR_W, then go to EXECUTE.
REQ-015 Opcode = IR[DATA_W-1:DATA_W-4]; operand address/immediate = IR[ADDR_W-1:0].
REQ-016 Memory opcodes: 1 ADD, 2 SHL, 3 SHR, 5 LD, 6 OR, 7 ST, 9 AND, A SUB, B XOR.
REQ-017 For memory opcodes, EXECUTE SHALL drive mem_req=1 and mem_addr=operand, and the result SHALL commit on ready.
REQ-018 Opcode 7 (ST) SHALL drive mem_we=1 and leave AC unchanged.
REQ-019 Memory-opcode results SHALL be:
- ADD: AC+M, modulo 2^DATA_W.
- SUB: AC-M, modulo 2^DATA_W.
- SHL / SHR: logical shift by M; M >= DATA_W gives 0.
- LD: AC<=M.
- OR / AND / XOR: bitwise with M.
REQ-020 Non-memory opcodes SHALL complete in one EXECUTE cycle with mem_req=0:
- 0 NOP: no effect.
- 4 LDI: AC<=zero-extended operand.
- 8 BR: PC<=operand.
- C BZ: PC<=operand if AC==0.
- D BN: PC<=operand if AC[DATA_W-1]==1.
- E: NOP.
- F HLT: go to HALT.
REQ-021 After any completed EXECUTE, next state SHALL be FETCH, except HLT, which goes to HALT.
REQ-022 With mem_ready=0, the FSM, PC, IR, AC and all memory outputs SHALL hold stable; wait length is unbounded.
REQ-023 HALT: mem_req=0, halted=1, registers frozen; leaves only via reset.
REQ-024 Fetch-execute latency SHALL be 2 cycles at zero wait states; each wait cycle adds one.
REQ-025 mem_req and mem_we SHALL be combinational from state and IR only, never from mem_ready.

Reset
REQ-026 Asserting reset SHALL immediately set state=FETCH, PC=0, IR=0, AC=0 and halted=0, even mid-access.
REQ-027 During reset, mem_req SHALL equal 1 with mem_addr=0 and mem_we=0; no write completes under reset.

Structure
REQ-028 A shared package SHALL hold the opcode constants, the FSM state encoding and the opcode-field position.
REQ-029 SHALL instantiate one combinational sub-module, param_acc_alu, that computes the memory-opcode results from AC, M and opcode.

Verification
REQ-030 Zero-wait program, mem[0]=LDI 5, mem[1]=ADD @10, mem[10]=7, mem[2]=ST @11 -> mem[11]=12 after 6 cycles; PC=3.
REQ-031 ADD with mem_ready held low 3 cycles -> AC, PC and mem_addr stable throughout; AC updates on the 4th EXECUTE cycle.
REQ-032 AC=0, then BZ 0x20 -> PC=0x20; AC=1, then BZ 0x20 -> PC unchanged. AC=0x80000000, then BN 0x30 -> PC=0x30.
REQ-033 AC=1, then SHL by M=32 -> AC=0. AC=0, then SUB M=1 -> AC=0xFFFFFFFF. PC=0xFFFF fetch -> PC wraps to 0.
REQ-034 Reset asserted mid-wait on ST -> mem_we drops the same cycle; AC=PC=0 and FETCH from address 0 after release.
REQ-035 HLT -> halted=1, mem_req=0 for 20 cycles; reset -> halted=0.

Source files
------------

// File: rtl/param_acc_cpu_pkg.sv
// ---------------------------------------------------------------------------
// param_acc_cpu_pkg
// Shared definitions for the accumulator CPU:
//   - FSM state encoding (FETCH / EXECUTE / HALT)
//   - opcode field width and position helper
//   - 4-bit opcode constants and memory-opcode classification
// No ports (package).
// ---------------------------------------------------------------------------
package param_acc_cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_HALT    = 2'd2
  } cpu_state_e;

  // The opcode always occupies the top OPC_W bits of the instruction word.
  localparam int OPC_W = 4;

  function automatic int opc_lsb(input int data_w);
    return data_w - OPC_W;
  endfunction

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BR   = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_SUB  = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BN   = 4'hD;
  localparam logic [3:0] OP_NOP2 = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Opcodes that need a data-memory access during EXECUTE.
  function automatic logic is_mem_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
      OP_ST, OP_AND, OP_SUB, OP_XOR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/param_acc_cpu_alu.sv
// ---------------------------------------------------------------------------
// param_acc_alu
// Combinational result unit for the memory opcodes.
// Ports:
//   ac     (in,  DATA_W) current accumulator
//   m      (in,  DATA_W) memory operand
//   opcode (in,  4)      instruction opcode
//   result (out, DATA_W) new accumulator value (equals ac for ST and
//                        any non-memory opcode)
// ---------------------------------------------------------------------------
module param_acc_alu
  import param_acc_cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] m,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result
);

  // Shift distances of DATA_W or more flush the accumulator to zero.
  logic shift_ovf;
  assign shift_ovf = (m >= DATA_W'(DATA_W));

  always_comb begin
    result = ac;
    case (opcode)
      OP_ADD: result = ac + m;
      OP_SUB: result = ac - m;
      OP_SHL: result = shift_ovf ? '0 : (ac << m);
      OP_SHR: result = shift_ovf ? '0 : (ac >> m);
      OP_LD:  result = m;
      OP_OR:  result = ac | m;
      OP_AND: result = ac & m;
      OP_XOR: result = ac ^ m;
      default: result = ac;
    endcase
  end

endmodule

// File: rtl/param_acc_cpu.sv
// ---------------------------------------------------------------------------
// param_acc_cpu
// Minimal accumulator CPU with a FETCH / EXECUTE / HALT state machine and a
// single ready-qualified memory port shared by instruction and data.
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   mem_req, mem_we         access request / write qualifier (from state+IR)
//   mem_addr  (ADDR_W)      PC in FETCH, operand address in EXECUTE
//   mem_wdata (DATA_W)      always the accumulator
//   mem_rdata (DATA_W)      read data, used when mem_req && mem_ready
//   mem_ready               completes the current access
//   PC, IR, AC              architectural registers for debug
//   halted                  high while in HALT
// ---------------------------------------------------------------------------
module param_acc_cpu
  import param_acc_cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] AC,
  output logic              halted
);

  localparam int OPC_LSB = opc_lsb(DATA_W);

  // The opcode field and the address field must not overlap.
  if (DATA_W < ADDR_W + OPC_W) begin : g_bad_widths
    $error("param_acc_cpu: DATA_W must be at least ADDR_W+4");
  end

  cpu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic              halted_q, halted_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              mem_op;
  logic [DATA_W-1:0] alu_result;

  assign opcode  = ir_q[OPC_LSB +: OPC_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign mem_op  = is_mem_op(opcode);

  param_acc_alu #(.DATA_W(DATA_W)) u_alu (
    .ac     (ac_q),
    .m      (mem_rdata),
    .opcode (opcode),
    .result (alu_result)
  );

  // Memory strobes depend only on state and IR so a slow memory can never
  // see its own ready feed back into the request.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
      end
      S_EXECUTE: begin
        mem_req  = mem_op;
        mem_we   = (opcode == OP_ST);
        mem_addr = operand;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Next-state logic: every transition out of FETCH or a memory EXECUTE
  // waits for mem_ready, so all registers hold during wait states.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ac_d     = ac_q;
    halted_d = halted_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (mem_op) begin
          if (mem_ready) begin
            ac_d    = alu_result;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
          case (opcode)
            OP_LDI: ac_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
            OP_BR:  pc_d = operand;
            OP_BZ:  if (ac_q == '0) pc_d = operand;
            OP_BN:  if (ac_q[DATA_W-1]) pc_d = operand;
            OP_HLT: begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      ac_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ac_q     <= ac_d;
      halted_q <= halted_d;
    end
  end

  assign mem_wdata = ac_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign AC        = ac_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_param_acc_cpu.sv
// ---------------------------------------------------------------------------
// tb_param_acc_cpu
// Directed programs for param_acc_cpu. A behavioural memory answers every
// request; each store the programs are expected to make is queued, and a
// monitor pops and compares whenever the DUT completes a write.
// ---------------------------------------------------------------------------
module tb_param_acc_cpu;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b1;
  logic [15:0] PC;
  logic [31:0] IR;
  logic [31:0] AC;
  logic        halted;

  logic [31:0] mem [0:65535];
  wr_t         exp_q[$];
  int          checkCount = 0;
  int          errorCount = 0;

  param_acc_cpu #(.DATA_W(32), .ADDR_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .PC        (PC),
    .IR        (IR),
    .AC        (AC),
    .halted    (halted)
  );

  // Posedges at 5, 15, 25 ...
  initial forever #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  function automatic logic [31:0] instr(input logic [3:0] op, input logic [15:0] opd);
    return {op, 12'h000, opd};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data);
    mem[addr] = data;
  endtask

  task automatic expectWrite(input logic [15:0] addr, input logic [31:0] data);
    exp_q.push_back('{addr: addr, data: data});
  endtask

  task automatic clearMem();
    for (int i = 0; i < 65536; i++) mem[16'(i)] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic waitHalted(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      cycles(1);
    end
    checkOutput(name, 32'(halted), 32'h1);
    checkOutput({name, "_sb_empty"}, 32'(exp_q.size()), 32'h0);
  endtask

  // Write monitor: samples just before each rising edge, when everything
  // driven by the bench and the DUT has settled, and performs the write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      #4;
      if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("write_data", mem_wdata, e.data);
        end
        mem[mem_addr] = mem_wdata;
      end
    end
  end

  initial begin
    clearMem();
    #1;
    // Reset state
    checkOutput("rst_pc",     32'(PC),      32'h0);
    checkOutput("rst_ir",     IR,           32'h0);
    checkOutput("rst_ac",     AC,           32'h0);
    checkOutput("rst_halted", 32'(halted),  32'h0);
    checkOutput("rst_req",    32'(mem_req), 32'h1);
    checkOutput("rst_we",     32'(mem_we),  32'h0);
    checkOutput("rst_addr",   32'(mem_addr),32'h0);

    // Basic program with zero wait states, then HALT behaviour
    applyStimulus(16'h0000, instr(4'h4, 16'h0005));
    applyStimulus(16'h0001, instr(4'h1, 16'h000A));
    applyStimulus(16'h0002, instr(4'h7, 16'h000B));
    applyStimulus(16'h0003, instr(4'hF, 16'h0000));
    applyStimulus(16'h000A, 32'd7);
    expectWrite(16'h000B, 32'd12);
    release_reset();
    cycles(6);
    checkOutput("t1_pc",    32'(PC), 32'h3);
    checkOutput("t1_ac",    AC,      32'd12);
    checkOutput("t1_mem11", mem[11], 32'd12);
    waitHalted("t1_halt", 20);
    for (int i = 0; i < 20; i++) begin
      checkOutput("halt_flag", 32'(halted),  32'h1);
      checkOutput("halt_req",  32'(mem_req), 32'h0);
      checkOutput("halt_pc",   32'(PC),      32'h4);
      cycles(1);
    end
    reset = 1'b1;
    #1;
    checkOutput("halt_rst_flag", 32'(halted), 32'h0);

    // Wait states during ADD
    clearMem();
    applyStimulus(16'h0000, instr(4'h4, 16'h0005));
    applyStimulus(16'h0001, instr(4'h1, 16'h000A));
    applyStimulus(16'h0002, instr(4'h7, 16'h000B));
    applyStimulus(16'h0003, instr(4'hF, 16'h0000));
    applyStimulus(16'h000A, 32'd7);
    expectWrite(16'h000B, 32'd12);
    release_reset();
    cycles(3);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      checkOutput("wait_ac",   AC,            32'd5);
      checkOutput("wait_pc",   32'(PC),       32'h2);
      checkOutput("wait_addr", 32'(mem_addr), 32'h000A);
      checkOutput("wait_req",  32'(mem_req),  32'h1);
    end
    mem_ready = 1'b1;
    cycles(1);
    checkOutput("wait_ac_commit", AC, 32'd12);
    waitHalted("t2_halt", 20);

    // Conditional branches
    reset = 1'b1;
    clearMem();
    applyStimulus(16'h0000, instr(4'h4, 16'h0000));
    applyStimulus(16'h0001, instr(4'hC, 16'h0020));
    applyStimulus(16'h0002, instr(4'h7, 16'h0100));
    applyStimulus(16'h0020, instr(4'h4, 16'h0001));
    applyStimulus(16'h0021, instr(4'hC, 16'h0040));
    applyStimulus(16'h0022, instr(4'h7, 16'h0101));
    applyStimulus(16'h0023, instr(4'h5, 16'h0050));
    applyStimulus(16'h0024, instr(4'hD, 16'h0030));
    applyStimulus(16'h0025, instr(4'h7, 16'h0102));
    applyStimulus(16'h0030, instr(4'h7, 16'h0103));
    applyStimulus(16'h0031, instr(4'hF, 16'h0000));
    applyStimulus(16'h0050, 32'h8000_0000);
    expectWrite(16'h0101, 32'h1);
    expectWrite(16'h0103, 32'h8000_0000);
    release_reset();
    cycles(4);
    checkOutput("bz_taken_pc", 32'(PC), 32'h0020);
    cycles(4);
    checkOutput("bz_not_taken_pc", 32'(PC), 32'h0022);
    waitHalted("t3_halt", 40);
    checkOutput("t3_final_pc", 32'(PC), 32'h0032);

    // ALU operations and shift boundaries
    reset = 1'b1;
    clearMem();
    applyStimulus(16'h0000, instr(4'h4, 16'h0001));
    applyStimulus(16'h0001, instr(4'h2, 16'h0060));
    applyStimulus(16'h0002, instr(4'h7, 16'h0110));
    applyStimulus(16'h0003, instr(4'hA, 16'h0061));
    applyStimulus(16'h0004, instr(4'h7, 16'h0111));
    applyStimulus(16'h0005, instr(4'h3, 16'h0062));
    applyStimulus(16'h0006, instr(4'h7, 16'h0112));
    applyStimulus(16'h0007, instr(4'h6, 16'h0064));
    applyStimulus(16'h0008, instr(4'h9, 16'h0065));
    applyStimulus(16'h0009, instr(4'h7, 16'h0113));
    applyStimulus(16'h000A, instr(4'hB, 16'h0063));
    applyStimulus(16'h000B, instr(4'h7, 16'h0114));
    applyStimulus(16'h000C, instr(4'h3, 16'h0066));
    applyStimulus(16'h000D, instr(4'h7, 16'h0115));
    applyStimulus(16'h000E, instr(4'hF, 16'h0000));
    applyStimulus(16'h0060, 32'd32);
    applyStimulus(16'h0061, 32'd1);
    applyStimulus(16'h0062, 32'd4);
    applyStimulus(16'h0063, 32'hF0F0_F0F0);
    applyStimulus(16'h0064, 32'hF000_0000);
    applyStimulus(16'h0065, 32'h00FF_00FF);
    applyStimulus(16'h0066, 32'h0000_0100);
    expectWrite(16'h0110, 32'h0000_0000);
    expectWrite(16'h0111, 32'hFFFF_FFFF);
    expectWrite(16'h0112, 32'h0FFF_FFFF);
    expectWrite(16'h0113, 32'h00FF_00FF);
    expectWrite(16'h0114, 32'hF00F_F00F);
    expectWrite(16'h0115, 32'h0000_0000);
    release_reset();
    waitHalted("t4_halt", 60);

    // PC wrap-around at the top of the address space
    reset = 1'b1;
    clearMem();
    applyStimulus(16'h0000, instr(4'hC, 16'hFFFF));
    applyStimulus(16'hFFFF, instr(4'h4, 16'h0001));
    applyStimulus(16'h0001, instr(4'h7, 16'h0120));
    applyStimulus(16'h0002, instr(4'hF, 16'h0000));
    expectWrite(16'h0120, 32'h1);
    release_reset();
    cycles(2);
    checkOutput("wrap_pre_pc", 32'(PC), 32'hFFFF);
    cycles(1);
    checkOutput("wrap_pc", 32'(PC), 32'h0000);
    checkOutput("wrap_ir", IR, instr(4'h4, 16'h0001));
    waitHalted("t5_halt", 30);

    // Reset asserted while a store is waiting
    reset = 1'b1;
    clearMem();
    applyStimulus(16'h0000, instr(4'h4, 16'h0009));
    applyStimulus(16'h0001, instr(4'h7, 16'h0040));
    applyStimulus(16'h0002, instr(4'hF, 16'h0000));
    release_reset();
    cycles(3);
    mem_ready = 1'b0;
    #1;
    checkOutput("st_wait_we",   32'(mem_we),   32'h1);
    checkOutput("st_wait_addr", 32'(mem_addr), 32'h0040);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_we",   32'(mem_we),   32'h0);
    checkOutput("mid_rst_req",  32'(mem_req),  32'h1);
    checkOutput("mid_rst_addr", 32'(mem_addr), 32'h0);
    checkOutput("mid_rst_ac",   AC,            32'h0);
    checkOutput("mid_rst_pc",   32'(PC),       32'h0);
    mem_ready = 1'b1;
    cycles(3);
    expectWrite(16'h0040, 32'h9);
    release_reset();
    #1;
    checkOutput("post_rst_addr", 32'(mem_addr), 32'h0);
    cycles(1);
    checkOutput("post_rst_ir", IR, instr(4'h4, 16'h0009));
    waitHalted("t6_halt", 30);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
